// File: rtl/pcie_tl_switch_param_if.sv
// Bundles the switch's configuration, data, flag and readback signals.
// The master side drives pushes, pops, thresholds and readback requests.
interface pcie_tl_switch_param_if #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned DW    = 10,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CW    = 5
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(NCH);

  logic              init;
  logic [AW:0]       umbral_alto;
  logic [AW:0]       umbral_bajo;
  logic [NCH*DW-1:0] data_in;
  logic [NCH-1:0]    push_in;
  logic [NCH-1:0]    almost_full_in;
  logic [NCH-1:0]    pop_out;
  logic [NCH*DW-1:0] data_out;
  logic [NCH-1:0]    empty_out;
  logic [NCH-1:0]    almost_empty_out;
  logic              req;
  logic [LW-1:0]     idx;
  logic [CW-1:0]     contador;
  logic              valid;
  logic [NCH-1:0]    overflow;
  logic [1:0]        state;

  modport master (
    output init, umbral_alto, umbral_bajo, data_in, push_in, pop_out, req, idx,
    input  almost_full_in, data_out, empty_out, almost_empty_out, contador, valid, overflow,
           state
  );

  modport slave (
    input  init, umbral_alto, umbral_bajo, data_in, push_in, pop_out, req, idx,
    output almost_full_in, data_out, empty_out, almost_empty_out, contador, valid, overflow,
           state
  );
endinterface

// File: rtl/pcie_tl_switch_param.sv
// Transaction-layer switch: NCH input FIFOs, round-robin arbiter routing each head word to
// the output FIFO named by its top bits, and per-output delivered-word counters.
module pcie_tl_switch_param #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned DW    = 10,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CW    = 5
) (
  input logic                 clk,
  input logic                 reset,
  pcie_tl_switch_param_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(NCH);
  localparam logic [AW:0] Full = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {StReset = 2'd0, StInit = 2'd1, StIdle = 2'd2, StActive = 2'd3} state_e;

  state_e        state_q;
  logic [DW-1:0] in_mem_q  [NCH][DEPTH];
  logic [DW-1:0] out_mem_q [NCH][DEPTH];
  logic [AW:0]   in_wr_q [NCH];
  logic [AW:0]   in_rd_q [NCH];
  logic [AW:0]   out_wr_q [NCH];
  logic [AW:0]   out_rd_q [NCH];
  logic [AW:0]   alto_q, bajo_q;
  logic [LW-1:0] rr_q;
  logic [CW-1:0] cnt_q [NCH];
  logic [CW-1:0] contador_q;
  logic          valid_q;
  logic [NCH-1:0] ovf_q;

  logic [AW:0]       in_occ [NCH];
  logic [AW:0]       out_occ [NCH];
  logic [DW-1:0]     in_head [NCH];
  logic              en, any_ne;
  logic [NCH-1:0]    push_ok, push_drop, pop_ok, in_pop, out_push;
  logic [NCH-1:0]    af, ee, ae;
  logic [NCH*DW-1:0] dout;
  logic              gnt_vld;
  logic [LW-1:0]     gnt_idx, gnt_dst, cand, cand_dst;
  logic [DW-1:0]     gnt_word;

  always_comb begin
    en     = (state_q != StReset);
    any_ne = 1'b0;
    af     = '0;
    ee     = '0;
    ae     = '0;
    dout   = '0;
    for (int i = 0; i < NCH; i++) begin
      in_occ[i]  = in_wr_q[i] - in_rd_q[i];
      out_occ[i] = out_wr_q[i] - out_rd_q[i];
      in_head[i] = in_mem_q[i][in_rd_q[i][AW-1:0]];
      any_ne     = any_ne | (in_occ[i] != '0) | (out_occ[i] != '0);
      push_ok[i]   = en & bus.push_in[i] & (in_occ[i] != Full);
      push_drop[i] = en & bus.push_in[i] & (in_occ[i] == Full);
      pop_ok[i]    = en & bus.pop_out[i] & (out_occ[i] != '0);
      af[i] = (in_occ[i] >= alto_q);
      ee[i] = (out_occ[i] == '0);
      ae[i] = (out_occ[i] <= bajo_q);
      dout[i*DW +: DW] = out_mem_q[i][out_rd_q[i][AW-1:0]];
    end
  end

  // Round-robin scan from rr_q; a head is eligible only if its destination has headroom.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    gnt_dst  = '0;
    gnt_word = '0;
    cand     = '0;
    cand_dst = '0;
    for (int k = 0; k < NCH; k++) begin
      cand     = rr_q + LW'(k);
      cand_dst = in_head[cand][DW-1 -: LW];
      if (state_q == StActive && !gnt_vld && in_occ[cand] != '0 &&
          out_occ[cand_dst] < alto_q && out_occ[cand_dst] != Full) begin
        gnt_vld  = 1'b1;
        gnt_idx  = cand;
        gnt_dst  = cand_dst;
        gnt_word = in_head[cand];
      end
    end
    for (int i = 0; i < NCH; i++) begin
      in_pop[i]   = gnt_vld && (gnt_idx == LW'(i));
      out_push[i] = gnt_vld && (gnt_dst == LW'(i));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StReset;
      alto_q     <= Full - 1'b1;
      bajo_q     <= (AW+1)'(1);
      rr_q       <= '0;
      contador_q <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= '0;
      for (int i = 0; i < NCH; i++) begin
        in_wr_q[i]  <= '0;
        in_rd_q[i]  <= '0;
        out_wr_q[i] <= '0;
        out_rd_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (push_ok[i])   in_wr_q[i]  <= in_wr_q[i] + 1'b1;
        if (in_pop[i])    in_rd_q[i]  <= in_rd_q[i] + 1'b1;
        if (out_push[i])  out_wr_q[i] <= out_wr_q[i] + 1'b1;
        if (push_drop[i]) ovf_q[i]    <= 1'b1;
        if (pop_ok[i]) begin
          out_rd_q[i] <= out_rd_q[i] + 1'b1;
          cnt_q[i]    <= cnt_q[i] + 1'b1;
        end
      end
      if (gnt_vld) rr_q <= gnt_idx + 1'b1;
      valid_q <= bus.req;
      if (bus.req) contador_q <= cnt_q[bus.idx];
      unique case (state_q)
        StReset: state_q <= StInit;
        StInit: begin
          alto_q <= (bus.umbral_alto > Full) ? Full : bus.umbral_alto;
          bajo_q <= bus.umbral_bajo;
          if (!bus.init) state_q <= StIdle;
        end
        StIdle: begin
          if (bus.init)    state_q <= StInit;
          else if (any_ne) state_q <= StActive;
        end
        StActive: begin
          if (bus.init)     state_q <= StInit;
          else if (!any_ne) state_q <= StIdle;
        end
      endcase
    end
  end

  // Storage needs no reset: pointers alone define what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (push_ok[i])  in_mem_q[i][in_wr_q[i][AW-1:0]]   <= bus.data_in[i*DW +: DW];
      if (out_push[i]) out_mem_q[i][out_wr_q[i][AW-1:0]] <= gnt_word;
    end
  end

  assign bus.almost_full_in   = af;
  assign bus.empty_out        = ee;
  assign bus.almost_empty_out = ae;
  assign bus.data_out         = dout;
  assign bus.contador         = contador_q;
  assign bus.valid            = valid_q;
  assign bus.overflow         = ovf_q;
  assign bus.state            = state_q;
endmodule

// File: tb/tb_pcie_tl_switch_param.sv
// Directed and randomized bench for pcie_tl_switch_param against a queue-based model.
module tb_pcie_tl_switch_param;
  localparam int NCH = 4, DW = 10, DEPTH = 8, CW = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  pcie_tl_switch_param_if #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH), .CW(CW)) bus ();
  pcie_tl_switch_param #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model: plain queues per FIFO plus scalar bookkeeping.
  logic [DW-1:0]  m_in  [NCH][$];
  logic [DW-1:0]  m_out [NCH][$];
  int             m_cnt [NCH];
  int             m_state, m_alto, m_bajo, m_rr, m_contador;
  bit             m_valid;
  logic [NCH-1:0] m_ovf;

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_in[i].delete();
      m_out[i].delete();
      m_cnt[i] = 0;
    end
    m_state = 0; m_alto = DEPTH - 1; m_bajo = 1; m_rr = 0;
    m_contador = 0; m_valid = 0; m_ovf = '0;
  endtask

  task automatic model_step();
    int gi, gd, d;
    bit anyne;
    bit popd [NCH];
    logic [DW-1:0] h;
    if (bus.req) begin
      m_contador = m_cnt[bus.idx];
      m_valid = 1;
    end else m_valid = 0;
    if (m_state == 0) begin
      m_state = 1;
      return;
    end
    anyne = 0;
    for (int i = 0; i < NCH; i++) if (m_in[i].size() != 0 || m_out[i].size() != 0) anyne = 1;
    gi = -1; gd = 0;
    if (m_state == 3) begin
      for (int k = 0; k < NCH; k++) begin
        int i;
        i = (m_rr + k) % NCH;
        if (gi < 0 && m_in[i].size() != 0) begin
          h = m_in[i][0];
          d = int'(h[DW-1 -: 2]);
          if (m_out[d].size() < m_alto && m_out[d].size() < DEPTH) begin
            gi = i; gd = d;
          end
        end
      end
    end
    for (int i = 0; i < NCH; i++) popd[i] = bus.pop_out[i] && m_out[i].size() != 0;
    for (int i = 0; i < NCH; i++) begin
      if (popd[i]) begin
        void'(m_out[i].pop_front());
        m_cnt[i] = (m_cnt[i] + 1) % (1 << CW);
      end
      if (bus.push_in[i]) begin
        if (m_in[i].size() == DEPTH) m_ovf[i] = 1'b1;
        else m_in[i].push_back(bus.data_in[i*DW +: DW]);
      end
    end
    if (gi >= 0) begin
      h = m_in[gi].pop_front();
      m_out[gd].push_back(h);
      m_rr = (gi + 1) % NCH;
    end
    if (m_state == 1) begin
      m_alto = (bus.umbral_alto > DEPTH) ? DEPTH : int'(bus.umbral_alto);
      m_bajo = int'(bus.umbral_bajo);
    end
    if (bus.init) m_state = 1;
    else if (m_state == 1) m_state = 2;
    else if (m_state == 2 && anyne) m_state = 3;
    else if (m_state == 3 && !anyne) m_state = 2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [NCH-1:0] e_empty, e_ae, e_af;
    logic [DW-1:0] h;
    for (int i = 0; i < NCH; i++) begin
      e_empty[i] = (m_out[i].size() == 0);
      e_ae[i]    = (m_out[i].size() <= m_bajo);
      e_af[i]    = (m_in[i].size() >= m_alto);
    end
    chk("state", 64'(bus.state), 64'(m_state));
    chk("empty_out", 64'(bus.empty_out), 64'(e_empty));
    chk("almost_empty_out", 64'(bus.almost_empty_out), 64'(e_ae));
    chk("almost_full_in", 64'(bus.almost_full_in), 64'(e_af));
    chk("overflow", 64'(bus.overflow), 64'(m_ovf));
    chk("valid", 64'(bus.valid), 64'(m_valid));
    chk("contador", 64'(bus.contador), 64'(m_contador));
    for (int d = 0; d < NCH; d++) begin
      if (m_out[d].size() != 0) begin
        h = m_out[d][0];
        chk($sformatf("data_out%0d", d), 64'(bus.data_out[d*DW +: DW]), 64'(h));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  logic [DW-1:0] order_exp [6];

  initial begin
    order_exp = '{10'h100, 10'h110, 10'h120, 10'h130, 10'h101, 10'h111};
    bus.init = 1'b1; bus.umbral_alto = 4'd6; bus.umbral_bajo = 4'd1;
    bus.data_in = '0; bus.push_in = '0; bus.pop_out = '0; bus.req = 1'b0; bus.idx = '0;
    reset = 1'b0;
    model_reset();
    repeat (2) begin
      @(posedge clk); #1; check_all();
    end
    chk("rst_state", 64'(bus.state), 64'd0);
    reset = 1'b1;
    tick(); chk("seq_init", 64'(bus.state), 64'd1);
    bus.init = 1'b0;
    tick(); chk("seq_idle", 64'(bus.state), 64'd2);
    chk("all_empty", 64'(bus.empty_out), 64'hF);
    chk("no_af", 64'(bus.almost_full_in), 64'h0);

    // Every input sends two words to output 1; arbitration stops at occupancy 6.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NCH; i++) bus.data_in[i*DW +: DW] = DW'(10'h100 | (i << 4) | k);
      bus.push_in = 4'hF;
      tick();
    end
    bus.push_in = '0;
    repeat (8) tick();
    chk("burst_state", 64'(bus.state), 64'd3);
    chk("burst_empty", 64'(bus.empty_out), 64'b1101);
    chk("burst_head", 64'(bus.data_out[DW +: DW]), 64'h100);

    bus.data_in = '0;
    for (int k = 0; k < 9; k++) begin
      bus.data_in[3*DW +: DW] = DW'(10'h140 + k);
      bus.push_in = 4'b1000;
      tick();
    end
    bus.push_in = '0;
    chk("ovf3", 64'(bus.overflow), 64'b1000);
    chk("af3", 64'(bus.almost_full_in[3]), 64'd1);

    bus.data_in = '0;
    bus.data_in[DW-1:0] = 10'h2A5; bus.push_in = 4'b0001;
    tick(); chk("lat_pre", 64'(bus.empty_out[2]), 64'd1);
    bus.data_in[DW-1:0] = 10'h2B6;
    tick(); chk("lat_2a5", 64'(bus.data_out[2*DW +: DW]), 64'h2A5);
    chk("lat_empty2", 64'(bus.empty_out[2]), 64'd0);
    bus.push_in = '0;
    repeat (2) tick();

    bus.pop_out = 4'b0100;
    repeat (5) tick();
    bus.pop_out = '0;
    chk("out2_drained", 64'(bus.empty_out[2]), 64'd1);
    bus.req = 1'b1; bus.idx = 2'd2;
    tick(); chk("cnt2", 64'(bus.contador), 64'd2); chk("valid1", 64'(bus.valid), 64'd1);
    bus.req = 1'b0;
    tick(); chk("valid0", 64'(bus.valid), 64'd0); chk("cnt_hold", 64'(bus.contador), 64'd2);

    for (int k = 0; k < 6; k++) begin
      chk("grant_order", 64'(bus.data_out[DW +: DW]), 64'(order_exp[k]));
      bus.pop_out = 4'b0010;
      tick();
    end
    bus.pop_out = '0;
    chk("ovf_sticky", 64'(bus.overflow[3]), 64'd1);

    repeat (300) begin
      for (int i = 0; i < NCH; i++) bus.data_in[i*DW +: DW] = DW'($urandom);
      bus.push_in = 4'($urandom);
      bus.pop_out = 4'($urandom);
      bus.req     = 1'($urandom);
      bus.idx     = 2'($urandom);
      bus.init    = ($urandom_range(0, 19) == 0);
      if (bus.init) begin
        bus.umbral_alto = 4'($urandom_range(0, 10));
        bus.umbral_bajo = 4'($urandom_range(0, 8));
      end
      tick();
    end

    bus.init = 1'b0; bus.pop_out = '0; bus.req = 1'b0; bus.push_in = 4'hF;
    repeat (3) tick();
    chk("pre_rst_active", 64'(bus.state), 64'd3);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("mid_rst_state", 64'(bus.state), 64'd0);
    chk("mid_rst_empty", 64'(bus.empty_out), 64'hF);
    chk("mid_rst_ovf", 64'(bus.overflow), 64'h0);
    @(posedge clk); #1; check_all();
    reset = 1'b1; bus.push_in = '0; bus.init = 1'b1;
    bus.umbral_alto = 4'd6; bus.umbral_bajo = 4'd1;
    tick();
    bus.init = 1'b0;
    tick();
    for (int i = 0; i < NCH; i++) begin
      bus.req = 1'b1; bus.idx = 2'(i);
      tick(); chk("cnt_after_rst", 64'(bus.contador), 64'd0);
    end
    bus.req = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
